// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: decodes instruction fields, sequences the datapath
// through a Moore FSM and owns the NZCV flag register.
module multicycle_control_unit #(
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            cond,
    input  logic [1:0]            op,
    input  logic [5:0]            funct,
    input  logic [3:0]            rd,
    input  logic [3:0]            alu_flags,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  reg_write,
    output logic                  mem_write,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [ALU_CTRL_W-1:0] alu_ctrl,
    output logic [1:0]            result_src,
    output logic [1:0]            imm_src,
    output logic [3:0]            state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = ALU_CTRL_W'(0);
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = ALU_CTRL_W'(1);
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = ALU_CTRL_W'(2);
    localparam logic [ALU_CTRL_W-1:0] ALU_ORR = ALU_CTRL_W'(3);

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [1:0] SRCA_REG = 2'b00;
    localparam logic [1:0] SRCA_PC  = 2'b01;
    localparam logic [1:0] SRCB_REG = 2'b00;
    localparam logic [1:0] SRCB_IMM = 2'b01;
    localparam logic [1:0] SRCB_4   = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_MEM    = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_flags;
    logic                    r_cond_ex_q;

    logic                    w_i;
    logic                    w_s_l;
    logic                    w_u;
    logic [3:0]              w_cmd;
    logic                    w_n;
    logic                    w_z;
    logic                    w_c;
    logic                    w_v;
    logic                    w_cond_ex;
    logic                    w_cmd_writes;
    logic                    w_cmd_arith;
    logic                    w_rd_pc;
    logic                    w_exec;
    logic [ALU_CTRL_W-1:0]   w_exec_alu;

    assign w_i     = funct[5];
    assign w_cmd   = funct[4:1];
    assign w_s_l   = funct[0];
    assign w_u     = funct[3];
    assign w_rd_pc = (rd == 4'd15);
    assign w_exec  = (r_state == S_EXECR) || (r_state == S_EXECI);

    assign {w_n, w_z, w_c, w_v} = r_flags;

    always_comb begin
        w_cond_ex = 1'b0;
        case (cond)
            4'b0000: w_cond_ex = w_z;
            4'b0001: w_cond_ex = ~w_z;
            4'b0010: w_cond_ex = w_c;
            4'b0011: w_cond_ex = ~w_c;
            4'b0100: w_cond_ex = w_n;
            4'b0101: w_cond_ex = ~w_n;
            4'b0110: w_cond_ex = w_v;
            4'b0111: w_cond_ex = ~w_v;
            4'b1000: w_cond_ex = w_c & ~w_z;
            4'b1001: w_cond_ex = ~w_c | w_z;
            4'b1010: w_cond_ex = (w_n == w_v);
            4'b1011: w_cond_ex = (w_n != w_v);
            4'b1100: w_cond_ex = ~w_z & (w_n == w_v);
            4'b1101: w_cond_ex = w_z | (w_n != w_v);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // Only these four commands have a result worth writing back; CMP and
    // unsupported commands retire straight from the execute state.
    always_comb begin
        w_cmd_writes = 1'b0;
        w_cmd_arith  = 1'b0;
        w_exec_alu   = ALU_ADD;
        case (w_cmd)
            CMD_ADD: begin w_cmd_writes = 1'b1; w_cmd_arith = 1'b1; w_exec_alu = ALU_ADD; end
            CMD_SUB: begin w_cmd_writes = 1'b1; w_cmd_arith = 1'b1; w_exec_alu = ALU_SUB; end
            CMD_CMP: begin w_cmd_arith  = 1'b1; w_exec_alu = ALU_SUB; end
            CMD_AND: begin w_cmd_writes = 1'b1; w_exec_alu = ALU_AND; end
            CMD_ORR: begin w_cmd_writes = 1'b1; w_exec_alu = ALU_ORR; end
            default: begin w_exec_alu = ALU_ADD; end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH: w_next_state = S_DECODE;
            S_DECODE: begin
                case (op)
                    2'b01:   w_next_state = S_MEMADR;
                    2'b00:   w_next_state = w_i ? S_EXECI : S_EXECR;
                    2'b10:   w_next_state = S_BRANCH;
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = w_s_l ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = S_MEMWB;
            S_MEMWB:  w_next_state = S_FETCH;
            S_MEMWR:  w_next_state = S_FETCH;
            S_EXECR:  w_next_state = w_cmd_writes ? S_ALUWB : S_FETCH;
            S_EXECI:  w_next_state = w_cmd_writes ? S_ALUWB : S_FETCH;
            S_ALUWB:  w_next_state = S_FETCH;
            S_BRANCH: w_next_state = S_FETCH;
            default:  w_next_state = S_FETCH;
        endcase
    end

    // Condition is frozen at the end of DECODE so later flag writes within the
    // same instruction cannot change its outcome.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cond_ex_q <= 1'b0;
        end else if (r_state == S_DECODE) begin
            r_cond_ex_q <= w_cond_ex;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flags <= 4'b0000;
        end else if (w_exec && w_s_l && r_cond_ex_q) begin
            r_flags[3:2] <= alu_flags[3:2];
            if (w_cmd_arith) begin
                r_flags[1:0] <= alu_flags[1:0];
            end
        end
    end

    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        alu_ctrl   = ALU_ADD;
        result_src = RES_ALUOUT;
        case (r_state)
            S_FETCH: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_4;
                result_src = RES_ALU;
            end
            S_DECODE: begin
                alu_src_a = SRCA_PC;
                alu_src_b = SRCB_4;
            end
            S_MEMADR: begin
                alu_src_b = SRCB_IMM;
                alu_ctrl  = w_u ? ALU_ADD : ALU_SUB;
            end
            S_MEMRD: adr_src = 1'b1;
            S_MEMWR: begin
                adr_src   = 1'b1;
                mem_write = r_cond_ex_q;
            end
            S_MEMWB: begin
                result_src = RES_MEM;
                reg_write  = r_cond_ex_q & ~w_rd_pc;
                pc_write   = r_cond_ex_q & w_rd_pc;
            end
            S_EXECR: alu_ctrl = w_exec_alu;
            S_EXECI: begin
                alu_src_b = SRCB_IMM;
                alu_ctrl  = w_exec_alu;
            end
            S_ALUWB: begin
                result_src = RES_ALUOUT;
                reg_write  = r_cond_ex_q & ~w_rd_pc;
                pc_write   = r_cond_ex_q & w_rd_pc;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_PC;
                alu_src_b  = SRCB_IMM;
                result_src = RES_ALU;
                pc_write   = r_cond_ex_q;
            end
            default: begin
                ir_write = 1'b0;
            end
        endcase
    end

    assign imm_src = op;
    assign state   = r_state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: directed test-plan instructions followed by
// random instructions, checked against an instruction-level reference model.
module tb_multicycle_control_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic [3:0] alu_flags;
    logic       ir_write, pc_write, adr_src, reg_write, mem_write;
    logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
    logic [3:0] alu_ctrl;
    logic [3:0] state;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] m_flags;

    multicycle_control_unit #(.ALU_CTRL_W(4)) dut (
        .clk(clk), .rst(rst), .cond(cond), .op(op), .funct(funct), .rd(rd),
        .alu_flags(alu_flags), .ir_write(ir_write), .pc_write(pc_write),
        .adr_src(adr_src), .reg_write(reg_write), .mem_write(mem_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
        .result_src(result_src), .imm_src(imm_src), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [16:0] obs_vec();
        return {ir_write, pc_write, adr_src, reg_write, mem_write, alu_src_a,
                alu_src_b, alu_ctrl, result_src, imm_src};
    endfunction

    function automatic logic [16:0] mk(input logic ir, input logic pc, input logic adr,
                                       input logic rw, input logic mw, input logic [1:0] a,
                                       input logic [1:0] b, input logic [3:0] alu,
                                       input logic [1:0] rs, input logic [1:0] imm);
        return {ir, pc, adr, rw, mw, a, b, alu, rs, imm};
    endfunction

    // Condition codes evaluated from named flags.
    function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            0: return z;           1: return !z;
            2: return cy;          3: return !cy;
            4: return n;           5: return !n;
            6: return v;           7: return !v;
            8: return cy && !z;    9: return !cy || z;
            10: return n == v;     11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Runs one instruction: the model lists the expected states and outputs,
    // then every cycle is compared starting from FETCH.
    task automatic run_instr(input string tag, input logic [3:0] c, input logic [1:0] o,
                             input logic [5:0] f, input logic [3:0] r, input logic [3:0] fl);
        int         st_q[$];
        logic [16:0] out_q[$];
        logic       cq;
        logic       wb_reg, wb_pc;
        logic [3:0] cmd;
        logic [3:0] alu;
        logic       writes, arith;
        cq     = m_cond(c, m_flags);
        wb_reg = cq && (r != 4'd15);
        wb_pc  = cq && (r == 4'd15);
        cmd    = f[4:1];
        st_q.push_back(0); out_q.push_back(mk(1, 1, 0, 0, 0, 2'b01, 2'b10, 4'd0, 2'b10, o));
        st_q.push_back(1); out_q.push_back(mk(0, 0, 0, 0, 0, 2'b01, 2'b10, 4'd0, 2'b00, o));
        if (o == 2'b01) begin
            st_q.push_back(2);
            out_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, 2'b01, f[3] ? 4'd0 : 4'd1, 2'b00, o));
            if (f[0]) begin
                st_q.push_back(3); out_q.push_back(mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 4'd0, 2'b00, o));
                st_q.push_back(4); out_q.push_back(mk(0, wb_pc, 0, wb_reg, 0, 2'b00, 2'b00, 4'd0, 2'b01, o));
            end else begin
                st_q.push_back(5); out_q.push_back(mk(0, 0, 1, 0, cq, 2'b00, 2'b00, 4'd0, 2'b00, o));
            end
        end else if (o == 2'b00) begin
            writes = 1'b1; arith = 1'b0; alu = 4'd0;
            case (cmd)
                4'b0100: begin alu = 4'd0; arith = 1'b1; end
                4'b0010: begin alu = 4'd1; arith = 1'b1; end
                4'b1010: begin alu = 4'd1; arith = 1'b1; writes = 1'b0; end
                4'b0000: alu = 4'd2;
                4'b1100: alu = 4'd3;
                default: writes = 1'b0;
            endcase
            st_q.push_back(f[5] ? 7 : 6);
            out_q.push_back(mk(0, 0, 0, 0, 0, 2'b00, f[5] ? 2'b01 : 2'b00, alu, 2'b00, o));
            if (writes) begin
                st_q.push_back(8); out_q.push_back(mk(0, wb_pc, 0, wb_reg, 0, 2'b00, 2'b00, 4'd0, 2'b00, o));
            end
            if (f[0] && cq) begin
                m_flags[3:2] = fl[3:2];
                if (arith) m_flags[1:0] = fl[1:0];
            end
        end else if (o == 2'b10) begin
            st_q.push_back(9); out_q.push_back(mk(0, cq, 0, 0, 0, 2'b01, 2'b01, 4'd0, 2'b10, o));
        end
        cond = c; op = o; funct = f; rd = r; alu_flags = fl;
        foreach (st_q[i]) begin
            chk({tag, "/state"}, 17'(state), 17'(st_q[i]));
            chk({tag, "/outs"}, obs_vec(), out_q[i]);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [3:0] rc;
        logic [1:0] ro;
        logic [5:0] rf;
        logic [3:0] rr;
        logic [3:0] rcmd;
        logic [3:0] cmd_tab [0:4];
        cmd_tab[0] = 4'b0100; cmd_tab[1] = 4'b0010; cmd_tab[2] = 4'b1010;
        cmd_tab[3] = 4'b0000; cmd_tab[4] = 4'b1100;

        rst = 1'b0; cond = 4'hE; op = 2'b11; funct = 6'd0; rd = 4'd0; alu_flags = 4'd0;
        m_flags = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset/state", 17'(state), 17'd0);
        chk("reset/outs", obs_vec(), mk(1, 1, 0, 0, 0, 2'b01, 2'b10, 4'd0, 2'b10, 2'b11));
        rst = 1'b1;

        run_instr("ldr", 4'hE, 2'b01, 6'b011001, 4'd3, 4'd0);
        run_instr("subs", 4'hE, 2'b00, 6'b000101, 4'd1, 4'b0110);
        run_instr("cmp_z1", 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
        run_instr("bne", 4'b0001, 2'b10, 6'd0, 4'd0, 4'd0);
        run_instr("beq", 4'b0000, 2'b10, 6'd0, 4'd0, 4'd0);
        run_instr("cmp_z0", 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0000);
        run_instr("streq_skip", 4'b0000, 2'b01, 6'b011000, 4'd2, 4'd0);
        run_instr("cmp_z1b", 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
        run_instr("streq_do", 4'b0000, 2'b01, 6'b011000, 4'd2, 4'd0);
        run_instr("add_pc", 4'hE, 2'b00, 6'b001000, 4'd15, 4'd0);
        run_instr("ands_keepcv", 4'hE, 2'b00, 6'b100001, 4'd4, 4'b1011);
        run_instr("nop", 4'hE, 2'b11, 6'd0, 4'd0, 4'd0);

        // Abort an LDR in MEMWB with an asynchronous reset while Z=1.
        run_instr("cmp_z1c", 4'hE, 2'b00, 6'b010101, 4'd0, 4'b0100);
        cond = 4'hE; op = 2'b01; funct = 6'b011001; rd = 4'd5;
        repeat (4) @(posedge clk);
        #1;
        chk("rst_pre/state", 17'(state), 17'd4);
        chk("rst_pre/reg_write", 17'(reg_write), 17'd1);
        #2 rst = 1'b0;
        m_flags = 4'd0;
        #1;
        chk("rst_mid/state", 17'(state), 17'd0);
        chk("rst_mid/reg_write", 17'(reg_write), 17'd0);
        repeat (2) begin
            @(posedge clk); #1;
            chk("rst_hold/state", 17'(state), 17'd0);
            chk("rst_hold/reg_write", 17'(reg_write), 17'd0);
        end
        rst = 1'b1;
        run_instr("strne_after_rst", 4'b0001, 2'b01, 6'b011000, 4'd2, 4'd0);
        run_instr("streq_after_rst", 4'b0000, 2'b01, 6'b011000, 4'd2, 4'd0);

        for (int k = 0; k < 60; k++) begin
            ro = 2'($urandom_range(0, 3));
            rc = ($urandom_range(0, 2) == 0) ? 4'hE : 4'($urandom_range(0, 15));
            rr = ($urandom_range(0, 3) == 0) ? 4'd15 : 4'($urandom_range(0, 14));
            rf = 6'($urandom_range(0, 63));
            if (ro == 2'b00 && $urandom_range(0, 3) != 0) begin
                rcmd = cmd_tab[$urandom_range(0, 4)];
                rf[4:1] = rcmd;
            end
            run_instr("rand", rc, ro, rf, rr, 4'($urandom_range(0, 15)));
        end
        chk("final/state", 17'(state), 17'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Control stage directly upstream of the datapath in main.
- Decodes the instruction fields from the datapath: cond, op, funct, rd.
- Runs a multicycle FSM and holds the NZCV flag register.
- Drives every datapath enable and mux select, replacing the hard-wired LDR/STR control in main.

Parameters:
ALU_CTRL_W, 4, width of alu_ctrl; must match the ALU S input.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
cond  input  4  instruction[31:28]
op  input  2  instruction[27:26]
funct  input  6  instruction[25:20]; [5]=I, [4:1]=cmd, [0]=S/L
rd  input  4  instruction[15:12]
alu_flags  input  4  ALU {N,Z,C,V}, valid in the execute states
ir_write  output  1  load instruction register
pc_write  output  1  load PC
adr_src  output  1  0=PC, 1=ALU result to memory address
reg_write  output  1  register file write enable
mem_write  output  1  data memory write enable
alu_src_a  output  2  00=reg A, 01=PC
alu_src_b  output  2  00=reg B, 01=extended imm, 10=constant 4
alu_ctrl  output  ALU_CTRL_W  0000 ADD, 0001 SUB, 0010 AND, 0011 ORR
result_src  output  2  00=ALU-out reg, 01=mem read data, 10=ALU result direct
imm_src  output  2  equals op: 00=8-bit DP, 01=12-bit mem, 10=24-bit branch
state  output  4  current FSM state (debug)

Behaviour:
- Reset (rst=0, async):
  - state=FETCH(0), flags=0000, cond_ex_q=0.
  - All enable outputs are driven from the state, so FETCH outputs apply during reset.
- Outputs are Moore, combinational from state plus latched fields. Defaults are all 0 / ADD.
- State encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXECR 6, EXECI 7, ALUWB 8, BRANCH 9.
- Transitions:
  - FETCH -> DECODE.
  - DECODE:
    - op=01 -> MEMADR
    - op=00, I=0 -> EXECR
    - op=00, I=1 -> EXECI
    - op=10 -> BRANCH
    - op=11 -> FETCH (NOP)
  - MEMADR: L=1 -> MEMRD, else MEMWR.
  - MEMRD -> MEMWB -> FETCH.
  - MEMWR -> FETCH.
  - EXECR/EXECI: cmd in {ADD 0100, SUB 0010, AND 0000, ORR 1100} -> ALUWB; otherwise (including CMP 1010) -> FETCH.
  - ALUWB -> FETCH.
  - BRANCH -> FETCH.
  - States 10-15 -> FETCH.
- Per-state outputs:
  - FETCH: ir_write=1, pc_write=1 (unconditional), adr_src=0, a=01, b=10, ADD, result_src=10.
  - DECODE: a=01, b=10, ADD. Produces PC+8 for the R15 read.
  - MEMADR: a=00, b=01, alu_ctrl = funct[3] (U) ? ADD : SUB.
  - MEMRD: adr_src=1.
  - MEMWR: adr_src=1, mem_write=cond_ex_q.
  - MEMWB: result_src=01.
  - ALUWB: result_src=00.
  - MEMWB and ALUWB write gating: reg_write = cond_ex_q & (rd!=15); pc_write = cond_ex_q & (rd==15).
  - EXECR: a=00, b=00, alu_ctrl from cmd (ADD/CMP->ADD/SUB as coded, SUB/CMP->SUB, AND->AND, ORR->ORR).
  - EXECI: as EXECR but b=01.
  - BRANCH: a=01, b=01, ADD, result_src=10, pc_write=cond_ex_q.
- Condition evaluation:
  - cond_ex is computed from the current flag register:
    - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
    - HI C&!Z, LS !C|Z, GE N==V, LT N!=V
    - GT !Z&(N==V), LE Z|(N!=V)
    - AL 1, 1111 -> 0
  - cond_ex_q is latched on the DECODE->next edge. All gating uses cond_ex_q, never live flags.
- Flag update, on the clock edge leaving EXECR/EXECI, when S=1 and cond_ex_q=1:
  - N,Z are always loaded.
  - C,V are loaded only for ADD/SUB/CMP.
  - AND/ORR keep the old C,V.
- Unconditional writes: ir_write and the FETCH pc_write never depend on cond_ex_q.
- Reset mid-instruction: the FSM returns to FETCH immediately and flags clear. No write enable may glitch high after rst falls.
- Latency:
  - LDR 5 cycles
  - STR 4
  - DP with writeback 4
  - CMP 3
  - branch 3
  - NOP 2

Test Plan:
1. LDR (cond=1110, op=01, funct=011001, rd=3) -> states 0,1,2,3,4. MEMADR alu_ctrl=0000. MEMWB: reg_write=1, result_src=01, pc_write=0.
2. SUBS R1 (funct=000101) with alu_flags=0110 in EXECR -> alu_ctrl=0001. Flags become 0110 after EXECR. ALUWB reg_write=1.
3. CMP sets Z=1, then BNE (cond=0001, op=10) -> BRANCH state with pc_write=0. Repeat with BEQ (0000) -> pc_write=1.
4. STR with cond=0000 while Z=0 -> MEMWR mem_write=0, and 4 cycles total. Repeat with Z=1 -> mem_write=1.
5. ADD with rd=15, cond=AL -> ALUWB: pc_write=1, reg_write=0.
6. Drive rst=0 during MEMWB -> state=0 and flags=0000 without waiting for a clock edge. reg_write stays 0 until the next full instruction.
